// File: rtl/l2_write_buffer.sv
// Write-back buffer between the L2 memory port and the cacheline adaptor: absorbs
// dirty evictions, forwards matching reads, and drains to memory while L2 is idle.
module l2_write_buffer #(
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  mem_address,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [255:0] mem_wdata256,
    output logic [255:0] mem_rdata256,
    output logic         mem_resp,
    output logic [31:0]  pmem_address,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [255:0] pmem_wdata,
    input  logic [255:0] pmem_rdata,
    input  logic         pmem_resp
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, RD_MEM, DRAIN, RESP} state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [PW-1:0]    head_q, head_d;
    logic [PW-1:0]    tail_q, tail_d;
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [26:0]      tag_q  [DEPTH];
    logic [26:0]      tag_d  [DEPTH];
    logic [255:0]     data_q [DEPTH];
    logic [255:0]     data_d [DEPTH];
    logic [255:0]     rdata_q, rdata_d;
    logic [31:0]      paddr_q, paddr_d;
    logic [255:0]     pwdata_q, pwdata_d;

    logic [26:0]      line_tag;
    logic             hit;
    logic [PW-1:0]    hit_idx;
    logic             full;
    logic             empty;
    logic             addr_offset_unused;

    assign line_tag           = mem_address[31:5];
    assign addr_offset_unused = ^mem_address[4:0];
    assign full               = (count_q == CNT_FULL);
    assign empty              = (count_q == '0);

    // Coalescing guarantees at most one valid entry per line, so no priority needed.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (tag_q[i] == line_tag)) begin
                hit     = 1'b1;
                hit_idx = PW'(i);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        head_d   = head_q;
        tail_d   = tail_q;
        valid_d  = valid_q;
        tag_d    = tag_q;
        data_d   = data_q;
        rdata_d  = rdata_q;
        paddr_d  = paddr_q;
        pwdata_d = pwdata_q;
        case (state_q)
            IDLE: begin
                if (mem_read) begin
                    if (hit) begin
                        rdata_d = data_q[hit_idx];
                        state_d = RESP;
                    end else begin
                        paddr_d = {line_tag, 5'b0};
                        state_d = RD_MEM;
                    end
                end else if (mem_write) begin
                    if (hit) begin
                        data_d[hit_idx] = mem_wdata256;
                        state_d         = RESP;
                    end else if (!full) begin
                        tag_d[tail_q]   = line_tag;
                        data_d[tail_q]  = mem_wdata256;
                        valid_d[tail_q] = 1'b1;
                        tail_d          = tail_q + PTR_ONE;
                        count_d         = count_q + CNT_ONE;
                        state_d         = RESP;
                    end else begin
                        // Write is left pending; it is re-evaluated once the head drains.
                        paddr_d  = {tag_q[head_q], 5'b0};
                        pwdata_d = data_q[head_q];
                        state_d  = DRAIN;
                    end
                end else if (!empty) begin
                    paddr_d  = {tag_q[head_q], 5'b0};
                    pwdata_d = data_q[head_q];
                    state_d  = DRAIN;
                end
            end
            RD_MEM: begin
                if (pmem_resp) begin
                    rdata_d = pmem_rdata;
                    state_d = RESP;
                end
            end
            DRAIN: begin
                if (pmem_resp) begin
                    valid_d[head_q] = 1'b0;
                    head_d          = head_q + PTR_ONE;
                    count_d         = count_q - CNT_ONE;
                    state_d         = IDLE;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            count_q  <= '0;
            head_q   <= '0;
            tail_q   <= '0;
            valid_q  <= '0;
            rdata_q  <= '0;
            paddr_q  <= '0;
            pwdata_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            valid_q  <= valid_d;
            rdata_q  <= rdata_d;
            paddr_q  <= paddr_d;
            pwdata_q <= pwdata_d;
        end
    end

    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end

    assign mem_resp     = (state_q == RESP);
    assign pmem_read    = (state_q == RD_MEM);
    assign pmem_write   = (state_q == DRAIN);
    assign mem_rdata256 = rdata_q;
    assign pmem_address = paddr_q;
    assign pmem_wdata   = pwdata_q;

    a_rd_wr_exclusive: assert property (@(posedge clk) disable iff (rst) !(mem_read && mem_write));

endmodule

// File: tb/tb_l2_write_buffer.sv
// Bench for l2_write_buffer: directed scenarios plus random L2 traffic, checked
// against a model made of an ordered list of buffered lines and a memory image.
module tb_l2_write_buffer;
    localparam int unsigned DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  mem_address;
    logic         mem_read;
    logic         mem_write;
    logic [255:0] mem_wdata256;
    logic [255:0] mem_rdata256;
    logic         mem_resp;
    logic [31:0]  pmem_address;
    logic         pmem_read;
    logic         pmem_write;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;

    always #5 clk = ~clk;

    l2_write_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
        .mem_wdata256(mem_wdata256), .mem_rdata256(mem_rdata256), .mem_resp(mem_resp),
        .pmem_address(pmem_address), .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    typedef struct {
        logic [31:0]  line;
        logic [255:0] data;
    } entry_t;

    entry_t       q[$];
    logic [255:0] memv  [logic [31:0]];
    logic [255:0] mem_m [logic [31:0]];
    logic [31:0]  drain_log[$];
    int unsigned  mem_lat;
    int           n_checks;
    int           n_fail;
    int           n_drains;
    logic         saw_rd;
    logic [31:0]  cur_line;
    int unsigned  lat;
    logic [255:0] a;
    logic [255:0] b;
    logic         any_wr;
    logic         started;
    logic [31:0]  lines [8];

    function automatic logic [255:0] init_pat(input logic [31:0] line);
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = line ^ (32'h9E37_79B9 * 32'(i + 1));
        return v;
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [255:0] mem_expect(input logic [31:0] line);
        return memv.exists(line) ? memv[line] : init_pat(line);
    endfunction

    function automatic int find_q(input logic [31:0] line);
        for (int i = 0; i < q.size(); i++) if (q[i].line == line) return i;
        return -1;
    endfunction

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Adaptor: answers each request after mem_lat further cycles; reset abandons it.
    initial begin : adaptor
        int unsigned alat;
        logic        aborted;
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        forever begin
            @(posedge clk); #1;
            pmem_resp = 1'b0;
            if (!rst && (pmem_read || pmem_write)) begin
                alat    = mem_lat;
                aborted = 1'b0;
                for (int unsigned k = 0; k < alat; k++) begin
                    @(posedge clk); #1;
                    if (rst) begin
                        aborted = 1'b1;
                        break;
                    end
                end
                if (!aborted && !rst) begin
                    if (pmem_write) mem_m[pmem_address] = pmem_wdata;
                    else pmem_rdata = mem_m.exists(pmem_address) ? mem_m[pmem_address]
                                                                 : init_pat(pmem_address);
                    pmem_resp = 1'b1;
                end
            end
        end
    end

    task automatic observe();
        if (pmem_resp) begin
            check_eq("pmem_rd_xor_wr", 256'(pmem_read ^ pmem_write), 256'(1));
            check_eq("pmem_addr_align", 256'(pmem_address[4:0]), 256'(0));
            if (pmem_write) begin
                n_drains++;
                drain_log.push_back(pmem_address);
                check_eq("drain_q_nonempty", 256'(q.size() != 0), 256'(1));
                if (q.size() != 0) begin
                    check_eq("drain_addr", 256'(pmem_address), 256'(q[0].line));
                    check_eq("drain_data", pmem_wdata, q[0].data);
                    memv[q[0].line] = q[0].data;
                    void'(q.pop_front());
                end
            end
            if (pmem_read) begin
                saw_rd = 1'b1;
                check_eq("rd_miss_addr", 256'(pmem_address), 256'(cur_line));
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        observe();
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) tick();
    endtask

    task automatic drain_all();
        int unsigned budget;
        budget = 0;
        while (q.size() != 0 && budget < 500) begin
            tick();
            budget++;
        end
        check_eq("drain_all_done", 256'(q.size()), 256'(0));
    endtask

    task automatic l2_req(input logic is_wr, input logic [31:0] addr, input logic [255:0] data,
                          output int unsigned rlat);
        logic [31:0] line;
        int          idx;
        logic        done;
        entry_t      e;
        line         = {addr[31:5], 5'b0};
        cur_line     = line;
        saw_rd       = 1'b0;
        mem_address  = addr;
        mem_wdata256 = data;
        mem_read     = !is_wr;
        mem_write    = is_wr;
        rlat         = 0;
        done         = 1'b0;
        while (!done && rlat < 200) begin
            tick();
            rlat++;
            if (mem_resp) done = 1'b1;
        end
        mem_read  = 1'b0;
        mem_write = 1'b0;
        check_eq("resp_seen", 256'(done), 256'(1));
        check_eq("no_pmem_in_resp", 256'(pmem_read | pmem_write), 256'(0));
        idx = find_q(line);
        if (is_wr) begin
            if (idx >= 0) q[idx].data = data;
            else begin
                e.line = line;
                e.data = data;
                q.push_back(e);
            end
            check_eq("occupancy_le_depth", 256'(q.size() <= DEPTH), 256'(1));
        end else begin
            check_eq("rd_data", mem_rdata256, (idx >= 0) ? q[idx].data : mem_expect(line));
            check_eq("rd_went_to_mem", 256'(saw_rd), 256'(idx < 0));
        end
        tick();
        check_eq("resp_one_cycle", 256'(mem_resp), 256'(0));
    endtask

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : main
        n_checks = 0; n_fail = 0; n_drains = 0;
        rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
        mem_address = '0; mem_wdata256 = '0; mem_lat = 1;
        saw_rd = 1'b0; cur_line = '0;
        lines = '{32'h0001_0000, 32'h0001_0020, 32'h0001_0040, 32'h8001_0000,
                  32'h0002_0000, 32'h0001_0060, 32'hFFFF_FFE0, 32'h0000_0000};
        #7;
        check_eq("rst_mem_resp", 256'(mem_resp), 256'(0));
        check_eq("rst_pmem_rw", 256'({pmem_read, pmem_write}), 256'(0));
        check_eq("rst_pmem_addr", 256'(pmem_address), 256'(0));
        idle(2);
        rst = 1'b0;
        idle(2);

        // Enqueue then drain on the following idle cycle.
        mem_lat = 3;
        a = rand256();
        l2_req(1'b1, 32'h0000_1020, a, lat);
        check_eq("t1_wr_lat", 256'(lat), 256'(1));
        tick();
        check_eq("t1_drain_wr", 256'(pmem_write), 256'(1));
        check_eq("t1_drain_addr", 256'(pmem_address), 256'(32'h0000_1020));
        check_eq("t1_drain_data", pmem_wdata, a);
        drain_all();

        // Read-after-write forwarding.
        a = rand256();
        l2_req(1'b1, 32'h0000_2000, a, lat);
        l2_req(1'b0, 32'h0000_2004, '0, lat);
        check_eq("t2_rd_lat", 256'(lat), 256'(1));
        check_eq("t2_fwd_data", mem_rdata256, a);
        check_eq("t2_no_pmem_read", 256'(saw_rd), 256'(0));
        drain_all();

        // Coalesce.
        a = rand256();
        b = rand256();
        l2_req(1'b1, 32'h0000_3000, a, lat);
        l2_req(1'b1, 32'h0000_3000, b, lat);
        check_eq("t3_coal_lat", 256'(lat), 256'(1));
        drain_log.delete();
        drain_all();
        idle(4);
        check_eq("t3_one_drain", 256'(drain_log.size()), 256'(1));

        // Full buffer: fifth write waits for one drain.
        mem_lat = 2;
        drain_log.delete();
        for (int i = 1; i <= 4; i++) begin
            l2_req(1'b1, 32'(i * 256), rand256(), lat);
            check_eq("t4_accept_lat", 256'(lat), 256'(1));
        end
        l2_req(1'b1, 32'h0000_0500, rand256(), lat);
        check_eq("t4_full_lat", 256'(lat), 256'(mem_lat + 3));
        check_eq("t4_first_drain", 256'(drain_log.size() == 1 ? drain_log[0] : 32'hFFFF_FFFF),
                 256'(32'h0000_0100));
        drain_all();
        check_eq("t4_drain_count", 256'(drain_log.size()), 256'(5));
        for (int i = 0; i < 5 && i < drain_log.size(); i++)
            check_eq("t4_drain_order", 256'(drain_log[i]), 256'(32'((i + 1) * 256)));

        // Read miss has priority over queued evictions.
        mem_lat = 1;
        l2_req(1'b1, 32'h0000_0100, rand256(), lat);
        drain_log.delete();
        l2_req(1'b0, 32'h0000_7FFC, '0, lat);
        check_eq("t5_miss_lat", 256'(lat), 256'(mem_lat + 2));
        check_eq("t5_miss_data", mem_rdata256, init_pat(32'h0000_7FE0));
        check_eq("t5_went_to_mem", 256'(saw_rd), 256'(1));
        check_eq("t5_no_drain_first", 256'(drain_log.size()), 256'(0));
        drain_all();

        // Reset in the middle of a drain.
        mem_lat = 20;
        a = rand256();
        l2_req(1'b1, 32'h0000_6000, a, lat);
        started = 1'b0;
        for (int i = 0; i < 10 && !started; i++) begin
            tick();
            started = pmem_write;
        end
        check_eq("t6_drain_started", 256'(started), 256'(1));
        #2 rst = 1'b1;
        #1;
        check_eq("t6_rst_pmem_write", 256'(pmem_write), 256'(0));
        check_eq("t6_rst_pmem_read", 256'(pmem_read), 256'(0));
        check_eq("t6_rst_mem_resp", 256'(mem_resp), 256'(0));
        check_eq("t6_rst_pmem_addr", 256'(pmem_address), 256'(0));
        check_eq("t6_rst_pmem_wdata", pmem_wdata, 256'(0));
        check_eq("t6_rst_rdata", mem_rdata256, 256'(0));
        q.delete();
        tick();
        rst = 1'b0;
        any_wr = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            any_wr = any_wr | pmem_write;
        end
        check_eq("t6_empty_after_rst", 256'(any_wr), 256'(0));
        mem_lat = 1;
        l2_req(1'b0, 32'h0000_6000, '0, lat);
        check_eq("t6_rd_miss", 256'(saw_rd), 256'(1));
        check_eq("t6_rd_old_mem", mem_rdata256, init_pat(32'h0000_6000));

        // Random traffic over a small line set so hits, coalescing and full stalls occur.
        for (int n = 0; n < 300; n++) begin
            mem_lat = $urandom_range(0, 3);
            l2_req(($urandom_range(0, 9) < 6), lines[$urandom_range(0, 7)] | 32'($urandom_range(0, 31)),
                   rand256(), lat);
            idle($urandom_range(0, 3));
        end
        drain_all();
        for (int i = 0; i < 8; i++) l2_req(1'b0, lines[i], '0, lat);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
